// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap controller:
// CSR addresses, cause codes, mstatus bit positions and FSM state.
package trap_pkg;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMie     = 12'h304;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;
  localparam logic [11:0] CsrMip     = 12'h344;

  localparam int unsigned CauseIllegal = 2;
  localparam int unsigned CauseLoadAf  = 5;
  localparam int unsigned CauseStoreAf = 7;
  localparam int unsigned CauseEcallM  = 11;
  localparam int unsigned IrqCauseBase = 16;

  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;

  typedef enum logic [1:0] {
    CsrOpNone  = 2'b00,
    CsrOpWrite = 2'b01,
    CsrOpSet   = 2'b10,
    CsrOpClear = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StSave,
    StRet
  } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// Machine-mode trap CSRs: storage, read mux, WARL masking and set/clear.
// One WB write port; the trap-save and mret ports override same-cycle WB writes.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_IRQ     = 4,
  parameter bit              VECTORED_EN = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [1:0]         op,
  input  logic [11:0]        addr,
  input  logic [XLEN-1:0]    wdata,
  output logic [XLEN-1:0]    rdata,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               save_en,
  input  logic [XLEN-1:0]    save_epc,
  input  logic [XLEN-1:0]    save_cause,
  input  logic [XLEN-1:0]    save_tval,
  input  logic               ret_en,
  output logic [XLEN-1:0]    mtvec,
  output logic [XLEN-1:0]    mepc,
  output logic [NUM_IRQ-1:0] mie,
  output logic               mstatus_mie
);

  logic               mstatus_mie_q, mstatus_mpie_q;
  logic [NUM_IRQ-1:0] mie_q;
  logic [XLEN-1:0]    mtvec_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0]    wval;
  logic               wr_en;

  assign mtvec       = mtvec_q;
  assign mepc        = mepc_q;
  assign mie         = mie_q;
  assign mstatus_mie = mstatus_mie_q;
  assign wr_en       = we && (op != CsrOpNone);

  always_comb begin
    rdata = '0;
    case (addr)
      CsrMstatus: begin
        rdata[MstatusMie]  = mstatus_mie_q;
        rdata[MstatusMpie] = mstatus_mpie_q;
      end
      CsrMie:    rdata[NUM_IRQ-1:0] = mie_q;
      CsrMtvec:  rdata = mtvec_q;
      CsrMepc:   rdata = mepc_q;
      CsrMcause: rdata = mcause_q;
      CsrMtval:  rdata = mtval_q;
      CsrMip:    rdata[NUM_IRQ-1:0] = irq;
      default:   rdata = '0;
    endcase
  end

  // Set/clear operate on the visible (already masked) value of the target CSR.
  always_comb begin
    wval = rdata;
    case (op)
      CsrOpWrite: wval = wdata;
      CsrOpSet:   wval = rdata | wdata;
      CsrOpClear: wval = rdata & ~wdata;
      default:    wval = rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      if (wr_en) begin
        case (addr)
          CsrMstatus: begin
            mstatus_mie_q  <= wval[MstatusMie];
            mstatus_mpie_q <= wval[MstatusMpie];
          end
          CsrMie:    mie_q    <= wval[NUM_IRQ-1:0];
          CsrMtvec:  mtvec_q  <= {wval[XLEN-1:2], 1'b0, wval[0] & VECTORED_EN};
          CsrMepc:   mepc_q   <= {wval[XLEN-1:2], 2'b00};
          CsrMcause: mcause_q <= wval;
          CsrMtval:  mtval_q  <= wval;
          default: ;
        endcase
      end
      // Later assignments win, so trap save / mret beat the WB write above.
      if (save_en) begin
        mepc_q         <= save_epc & ~XLEN'(3);
        mcause_q       <= save_cause;
        mtval_q        <= save_tval;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end
      if (ret_en) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller beside WB: prioritises exceptions and interrupts,
// flushes the pipe, saves trap state in one cycle and redirects IF.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_IRQ     = 4,
  parameter bit              VECTORED_EN = 1'b1,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_we,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  output logic [XLEN-1:0]    csr_rdata,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               illegal_inst,
  input  logic               l_access_fault,
  input  logic               s_access_fault,
  input  logic               ecall_m,
  input  logic               mret,
  input  logic [XLEN-1:0]    fault_addr,
  input  logic [XLEN-1:0]    epc_cur,
  input  logic [XLEN-1:0]    epc_next,
  output logic [XLEN-1:0]    pc_redirect,
  output logic               redirect_valid,
  output logic               flush_fd,
  output logic               flush_de,
  output logic               flush_em,
  output logic               flush_mw,
  output logic               regwrite_cancel,
  output logic               trap_busy
);

  trap_state_e state_q, state_d;

  logic [XLEN-1:0]    mtvec, mepc, base;
  logic [NUM_IRQ-1:0] mie, irq_act;
  logic               mstatus_mie;
  logic               exc, irq_pend, trap, latch, save_en, ret_en, wb_we;
  logic [4:0]         irq_idx;
  logic [XLEN-1:0]    cause_d, tval_d, epc_d, target_d;
  logic [XLEN-1:0]    cause_q, tval_q, epc_q, target_q;

  assign exc      = illegal_inst | ecall_m | l_access_fault | s_access_fault;
  assign irq_act  = irq & mie;
  assign irq_pend = mstatus_mie & (|irq_act);
  assign trap     = exc | irq_pend;
  assign base     = mtvec & ~XLEN'(3);

  // Descending scan so the lowest pending index is the last assignment.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_act[i]) irq_idx = 5'(i);
    end
  end

  always_comb begin
    cause_d  = '0;
    tval_d   = '0;
    epc_d    = epc_cur;
    target_d = base;
    if (illegal_inst) begin
      cause_d = XLEN'(CauseIllegal);
    end else if (ecall_m) begin
      cause_d = XLEN'(CauseEcallM);
    end else if (l_access_fault) begin
      cause_d = XLEN'(CauseLoadAf);
      tval_d  = fault_addr;
    end else if (s_access_fault) begin
      cause_d = XLEN'(CauseStoreAf);
      tval_d  = fault_addr;
    end else begin
      cause_d = {1'b1, (XLEN-1)'(IrqCauseBase + 32'(irq_idx))};
      epc_d   = epc_next;
      if (mtvec[0]) target_d = base + (XLEN'(IrqCauseBase + 32'(irq_idx)) << 2);
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_redirect     = '0;
    redirect_valid  = 1'b0;
    flush_fd        = 1'b0;
    flush_de        = 1'b0;
    flush_em        = 1'b0;
    flush_mw        = 1'b0;
    regwrite_cancel = 1'b0;
    latch           = 1'b0;
    save_en         = 1'b0;
    ret_en          = 1'b0;
    wb_we           = csr_we;
    unique case (state_q)
      StIdle: begin
        if (trap) begin
          state_d         = StSave;
          flush_fd        = 1'b1;
          flush_de        = 1'b1;
          flush_em        = 1'b1;
          flush_mw        = 1'b1;
          regwrite_cancel = exc;
          latch           = 1'b1;
          // An interrupted WB instruction still commits its CSR write.
          if (exc) wb_we = 1'b0;
        end else if (mret) begin
          state_d  = StRet;
          flush_fd = 1'b1;
          flush_de = 1'b1;
          flush_em = 1'b1;
        end
      end
      StSave: begin
        state_d        = StIdle;
        redirect_valid = 1'b1;
        pc_redirect    = target_q;
        flush_fd       = 1'b1;
        save_en        = 1'b1;
      end
      StRet: begin
        state_d        = StIdle;
        redirect_valid = 1'b1;
        pc_redirect    = mepc;
        flush_fd       = 1'b1;
        ret_en         = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign trap_busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cause_q  <= '0;
      tval_q   <= '0;
      epc_q    <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        cause_q  <= cause_d;
        tval_q   <= tval_d;
        epc_q    <= epc_d;
        target_q <= target_d;
      end
    end
  end

  trap_csr_file #(
    .XLEN        (XLEN),
    .NUM_IRQ     (NUM_IRQ),
    .VECTORED_EN (VECTORED_EN),
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr (
    .clk         (clk),
    .rst         (rst),
    .we          (wb_we),
    .op          (csr_op),
    .addr        (csr_addr),
    .wdata       (csr_wdata),
    .rdata       (csr_rdata),
    .irq         (irq),
    .save_en     (save_en),
    .save_epc    (epc_q),
    .save_cause  (cause_q),
    .save_tval   (tval_q),
    .ret_en      (ret_en),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .mie         (mie),
    .mstatus_mie (mstatus_mie)
  );

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected redirect targets go into a scoreboard
// queue drained by a negedge monitor; CSR/flush values are checked inline.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_we;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic [3:0]  irq;
  logic        illegal_inst, l_access_fault, s_access_fault, ecall_m, mret;
  logic [31:0] fault_addr, epc_cur, epc_next, pc_redirect;
  logic        redirect_valid, flush_fd, flush_de, flush_em, flush_mw;
  logic        regwrite_cancel, trap_busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  trap_ctrl #(
    .XLEN        (32),
    .NUM_IRQ     (4),
    .VECTORED_EN (1'b1),
    .MTVEC_RESET (32'h40)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .csr_we          (csr_we),
    .csr_op          (csr_op),
    .csr_addr        (csr_addr),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata),
    .irq             (irq),
    .illegal_inst    (illegal_inst),
    .l_access_fault  (l_access_fault),
    .s_access_fault  (s_access_fault),
    .ecall_m         (ecall_m),
    .mret            (mret),
    .fault_addr      (fault_addr),
    .epc_cur         (epc_cur),
    .epc_next        (epc_next),
    .pc_redirect     (pc_redirect),
    .redirect_valid  (redirect_valid),
    .flush_fd        (flush_fd),
    .flush_de        (flush_de),
    .flush_em        (flush_em),
    .flush_mw        (flush_mw),
    .regwrite_cancel (regwrite_cancel),
    .trap_busy       (trap_busy)
  );

  always #5 clk = ~clk;

  // Monitor: every presented redirect must match the oldest expected target.
  always @(negedge clk) begin
    n_checks++;
    if (redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_redirect: got pc %h, required no redirect", pc_redirect);
      end else begin
        mon_exp = exp_q.pop_front();
        if (pc_redirect !== mon_exp) begin
          n_fail++;
          $display("FAIL redirect_target: got %h, required %h", pc_redirect, mon_exp);
        end
      end
    end else if (pc_redirect !== 32'h0) begin
      n_fail++;
      $display("FAIL redirect_idle_zero: got %h, required 00000000", pc_redirect);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
    step();
    csr_we = 1'b0; csr_op = 2'b00; csr_wdata = '0;
  endtask

  task automatic rd(input string nm, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(nm, csr_rdata, exp);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_pending_redirects"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    step();
  endtask

  task automatic clear_events();
    illegal_inst = 0; l_access_fault = 0; s_access_fault = 0; ecall_m = 0; mret = 0;
    irq = '0; csr_we = 0; csr_op = 2'b00;
  endtask

  task automatic check_flush(input string nm, input logic [4:0] exp);
    check(nm, {27'h0, flush_fd, flush_de, flush_em, flush_mw, regwrite_cancel}, {27'h0, exp});
  endtask

  typedef struct {
    logic ill, ec, lf, sf;
    logic [31:0] cause, tval;
  } prio_t;

  prio_t prio_tab[3];

  initial begin
    prio_tab[0] = '{ill: 0, ec: 1, lf: 1, sf: 0, cause: 32'd11, tval: 32'h0};
    prio_tab[1] = '{ill: 0, ec: 0, lf: 1, sf: 1, cause: 32'd5,  tval: 32'h1234};
    prio_tab[2] = '{ill: 0, ec: 0, lf: 0, sf: 1, cause: 32'd7,  tval: 32'h1234};

    rst = 1; clear_events(); csr_addr = '0; csr_wdata = '0;
    fault_addr = '0; epc_cur = '0; epc_next = '0;
    repeat (3) step();
    rst = 0;
    check_flush("reset_flushes", 5'b00000);
    check("reset_busy", {31'h0, trap_busy}, 32'h0);
    rd("reset_mtvec", 12'h305, 32'h40);
    rd("reset_mstatus", 12'h300, 32'h0);
    rd("reset_mcause", 12'h342, 32'h0);

    // WARL masking on mtvec / mepc.
    csr_wr(2'b01, 12'h305, 32'h203);
    rd("mtvec_warl", 12'h305, 32'h201);
    csr_wr(2'b01, 12'h305, 32'h200);
    csr_wr(2'b01, 12'h341, 32'h107);
    rd("mepc_warl", 12'h341, 32'h104);

    // Illegal instruction, direct mode.
    illegal_inst = 1; epc_cur = 32'h100; exp_q.push_back(32'h200);
    @(negedge clk);
    check_flush("ill_detect_flush", 5'b11111);
    check("ill_detect_busy", {31'h0, trap_busy}, 32'h0);
    step();
    clear_events();
    check("ill_save_busy", {31'h0, trap_busy}, 32'h1);
    check("ill_save_flush_de", {31'h0, flush_de}, 32'h0);
    rd("ill_save_pre_mcause", 12'h342, 32'h0);
    rd("ill_save_pre_mepc", 12'h341, 32'h104);
    step();
    rd("ill_mepc", 12'h341, 32'h100);
    rd("ill_mcause", 12'h342, 32'h2);
    rd("ill_mstatus", 12'h300, 32'h0);
    drain("ill");

    // Vectored interrupt; WB CSR write of the interrupted instruction commits.
    csr_wr(2'b01, 12'h305, 32'h201);
    csr_wr(2'b01, 12'h304, 32'h4);
    csr_wr(2'b10, 12'h300, 32'h8);
    rd("irq_mstatus_set", 12'h300, 32'h8);
    irq = 4'b0100; epc_cur = 32'h80; epc_next = 32'h84;
    csr_we = 1; csr_op = 2'b01; csr_addr = 12'h343; csr_wdata = 32'h55;
    exp_q.push_back(32'h248);
    @(negedge clk);
    check_flush("irq_detect_flush", 5'b11110);
    step();
    clear_events();
    rd("irq_save_wb_write", 12'h343, 32'h55);
    step();
    rd("irq_mcause", 12'h342, 32'h8000_0012);
    rd("irq_mepc", 12'h341, 32'h84);
    rd("irq_mtval", 12'h343, 32'h0);
    rd("irq_mstatus", 12'h300, 32'h80);
    drain("irq");

    // mret back to the interrupted PC.
    mret = 1; exp_q.push_back(32'h84);
    @(negedge clk);
    check_flush("mret_detect_flush", 5'b11100);
    step();
    clear_events();
    check("mret_busy", {31'h0, trap_busy}, 32'h1);
    rd("mret_pre_mstatus", 12'h300, 32'h80);
    step();
    rd("mret_mstatus", 12'h300, 32'h88);
    drain("mret");

    // Masked by MIE=0: no trap, mip mirrors irq.
    csr_wr(2'b11, 12'h300, 32'h8);
    csr_wr(2'b01, 12'h304, 32'h1);
    irq = 4'b0001;
    @(negedge clk);
    check_flush("masked_flush", 5'b00000);
    step();
    check("masked_busy", {31'h0, trap_busy}, 32'h0);
    rd("mip_read", 12'h344, 32'h1);
    clear_events();

    // Lowest pending index wins.
    csr_wr(2'b10, 12'h300, 32'h8);
    csr_wr(2'b01, 12'h304, 32'hE);
    irq = 4'b1110; epc_next = 32'h90; exp_q.push_back(32'h244);
    @(negedge clk);
    check_flush("irq1_detect_flush", 5'b11110);
    step();
    clear_events();
    step();
    rd("irq1_mcause", 12'h342, 32'h8000_0011);
    rd("irq1_mepc", 12'h341, 32'h90);
    drain("irq1");

    // Exception beats interrupt; trapping instruction's CSR write dropped.
    csr_wr(2'b10, 12'h300, 32'h8);
    csr_wr(2'b01, 12'h304, 32'h1);
    illegal_inst = 1; l_access_fault = 1; irq = 4'b0001;
    fault_addr = 32'hdead0; epc_cur = 32'h300;
    csr_we = 1; csr_op = 2'b01; csr_addr = 12'h304; csr_wdata = 32'hF;
    exp_q.push_back(32'h200);
    @(negedge clk);
    check_flush("mix_detect_flush", 5'b11111);
    step();
    clear_events();
    step();
    rd("mix_mcause", 12'h342, 32'h2);
    rd("mix_mie", 12'h304, 32'h1);
    rd("mix_mtval", 12'h343, 32'h0);
    rd("mix_mepc", 12'h341, 32'h300);
    rd("mix_mstatus", 12'h300, 32'h80);
    drain("mix");

    // Exception priority table.
    for (int k = 0; k < 3; k++) begin
      illegal_inst = prio_tab[k].ill; ecall_m = prio_tab[k].ec;
      l_access_fault = prio_tab[k].lf; s_access_fault = prio_tab[k].sf;
      fault_addr = 32'h1234; epc_cur = 32'h400 + 32'(k) * 4;
      exp_q.push_back(32'h200);
      @(negedge clk);
      check_flush($sformatf("prio%0d_flush", k), 5'b11111);
      step();
      clear_events();
      step();
      rd($sformatf("prio%0d_mcause", k), 12'h342, prio_tab[k].cause);
      rd($sformatf("prio%0d_mtval", k), 12'h343, prio_tab[k].tval);
      rd($sformatf("prio%0d_mepc", k), 12'h341, 32'h400 + 32'(k) * 4);
      drain($sformatf("prio%0d", k));
    end

    // Back-to-back: ecall held during SAVE is ignored, then taken in IDLE.
    illegal_inst = 1; epc_cur = 32'h10; exp_q.push_back(32'h200);
    step();
    illegal_inst = 0; ecall_m = 1; epc_cur = 32'h20;
    check("b2b_save_busy", {31'h0, trap_busy}, 32'h1);
    exp_q.push_back(32'h200);
    step();
    @(negedge clk);
    check_flush("b2b_second_detect", 5'b11111);
    step();
    clear_events();
    step();
    rd("b2b_mcause", 12'h342, 32'd11);
    rd("b2b_mepc", 12'h341, 32'h20);
    drain("b2b");

    // Reset during SAVE aborts the save.
    ecall_m = 1; epc_cur = 32'h500; exp_q.push_back(32'h200);
    @(negedge clk);
    check_flush("rst_detect_flush", 5'b11111);
    step();
    clear_events();
    rst = 1;
    step();
    rst = 0;
    check("rst_abort_redirect", {31'h0, redirect_valid}, 32'h0);
    check("rst_abort_busy", {31'h0, trap_busy}, 32'h0);
    rd("rst_abort_mcause", 12'h342, 32'h0);
    rd("rst_abort_mepc", 12'h341, 32'h0);
    rd("rst_abort_mtvec", 12'h305, 32'h40);
    drain("rst_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Parametrised machine-mode trap controller for the pipelined RV32 core: the next generation of the exception unit. It adds `NUM_IRQ` maskable external interrupt lines, mie/mip/mtval CSRs, and direct/vectored mtvec. It also writes mepc/mcause/mtval/mstatus together in a single save cycle. It sits beside WB and receives trap causes from WB, CSR accesses from WB, and drives IF redirect plus per-stage flushes.

## Interface
- `XLEN`, 32, data/PC width
- `NUM_IRQ`, 4, external interrupt lines, legal 1..16
- `VECTORED_EN`, 1, 1 enables mtvec mode 01 (vectored)
- `MTVEC_RESET`, 0, mtvec reset value
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, **synchronous, active-high**
- `csr_we`  in  1  WB CSR instruction commits
- `csr_op`  in  2  01 write, 10 set, 11 clear
- `csr_addr`  in  12  CSR address (read and write)
- `csr_wdata`  in  XLEN  operand, already imm/reg muxed
- `csr_rdata`  out  XLEN  combinational read of `csr_addr`; unimplemented reads 0
- `irq`  in  NUM_IRQ  level-sensitive interrupt requests
- `illegal_inst`, `l_access_fault`, `s_access_fault`, `ecall_m`, `mret`  in  1 each  WB-stage events
- `fault_addr`  in  XLEN  value for mtval on access faults
- `epc_cur`  in  XLEN  PC of WB instruction
- `epc_next`  in  XLEN  oldest unflushed next PC
- `pc_redirect`  out  XLEN  IF target
- `redirect_valid`  out  1  select `pc_redirect` in IF
- `flush_fd`, `flush_de`, `flush_em`, `flush_mw`  out  1 each  pipeline register flushes
- `regwrite_cancel`  out  1  suppress WB register write
- `trap_busy`  out  1  state != IDLE

## Operation
- CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, other bits read 0), mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (read-only, equals `irq`).
- mtvec writes: bit 1 forced 0. Bit 0 forced 0 if `VECTORED_EN`=0. mepc bits[1:0] forced 0.
- Exception priority: illegal (cause 2, mtval 0) > ecall (11, mtval 0) > load fault (5, mtval=`fault_addr`) > store fault (7, mtval=`fault_addr`).
- Interrupt pending: MIE & |(irq & mie). Lowest index i wins. mcause = {1, 16+i}. mtval 0.
- Exceptions beat interrupts. Either beats `mret`.
- Target: base = {mtvec[XLEN-1:2],00}. If the trap is an interrupt and mtvec[0]=1, target = base + 4*(16+i). Otherwise target = base.
- FSM states: IDLE, SAVE, RET.
  - IDLE→SAVE: on trap.
  - IDLE→RET: on `mret` with no trap.
  - SAVE→IDLE and RET→IDLE: unconditional.
  - Trap/mret inputs are ignored outside IDLE.
- Detect cycle (IDLE, combinational):
  - All four flushes assert.
  - `regwrite_cancel`=1 for exceptions only.
  - Trapping instruction's CSR write is dropped.
  - Cause, epc, tval and target are latched.
  - epc = `epc_cur` for an exception, `epc_next` for an interrupt. On an interrupt the WB instruction completes, including its CSR write.
- SAVE: `redirect_valid`=1 with the latched target, `flush_fd`=1. At the end of the cycle write mepc, mcause, mtval, and mstatus with MPIE←MIE, MIE←0. These writes override any same-cycle WB write.
- mret detect cycle: flushes FD/DE/EM. Then RET: `redirect_valid`=1, `pc_redirect`=mepc, `flush_fd`=1. At the end of the cycle MIE←MPIE, MPIE←1.
- Reset: all CSRs 0 except mtvec=`MTVEC_RESET`. State IDLE. All outputs 0.
- Reset mid-SAVE/RET aborts the operation: no CSR update, no redirect next cycle.

## Timing
- Trap latency: detect at cycle T (flush same cycle), redirect in T+1, CSR state visible in T+2.
- `csr_rdata` in T+1 returns pre-trap values.
- `pc_redirect` holds 0 whenever `redirect_valid`=0.
- Normal CSR writes take effect at the clock edge of the commit cycle.
- Back-to-back: a trap in the cycle after SAVE is accepted normally.

## Structure
- Package `trap_pkg`: CSR address constants, cause codes, mstatus bit indices, state enum.
- Sub-module `trap_csr_file`: CSR storage, read mux, WARL masking, and set/clear logic. It has one WB write port plus a trap-save port.

## Test plan
- mtvec=0x200, `illegal_inst` with epc_cur=0x100 → flushes+cancel at T, redirect 0x200 at T+1, mepc=0x100, mcause=2, MIE=0.
- mtvec=0x201, mie=0x4, MIE=1, irq=0b0100, epc_next=0x84 → no cancel, redirect 0x248, mcause=0x80000012, mepc=0x84.
- After the previous case, `mret` → redirect 0x84 at T+1, MIE=1, MPIE=1.
- MIE=0, irq=0b0001, mie=1 → no trap. Read 0x344 returns 1.
- `illegal_inst`+`l_access_fault`+irq+csr_we write mie=0xF in one cycle → mcause=2, mie unchanged.
- `ecall_m`, assert rst during SAVE → next cycle `redirect_valid`=0, mcause=0, state IDLE.
